// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-style controller.
// Holds the state enum, the supported opcodes and the datapath select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        WB_R     = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // Successor of DECODE; anything not listed is unsupported and traps.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return EXEC_R;
            OP_LW, OP_SW: return MEM_ADDR;
            OP_ADDI:      return EXEC_I;
            OP_BEQ:       return BRANCH;
            OP_J:         return JUMP;
            default:      return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: decoder/ALU/memory status in, strobes and selects out.
// mem_rd/mem_wr act as a request that is held, with stable iord, until mem_ready completes it.
interface mc_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             zero;
    logic             ir_we;
    logic             pc_we;
    logic             mem_rd;
    logic             mem_wr;
    logic             iord;
    logic             reg_we;
    logic             regdst;
    logic             memtoreg;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [1:0]       pcsrc;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, mem_ready, zero,
        output ir_we, pc_we, mem_rd, mem_wr, iord, reg_we, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, illegal, state, instr_cnt
    );

    modport slave (
        output opcode, funct, mem_ready, zero,
        input  ir_we, pc_we, mem_rd, mem_wr, iord, reg_we, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, illegal, state, instr_cnt
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle controller FSM: sequences fetch/decode/execute, counts retired
// instructions and traps on unsupported opcodes until reset.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         rst,
    mc_control_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEM_WB, WB_R, WB_I, BRANCH, JUMP: retire = 1'b1;
            MEM_WR:                           retire = bus.mem_ready;
            EXEC_R:                           retire = (bus.funct == FUNCT_JR);
            default:                          retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            op_q      <= 6'h00;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (retire) cnt_q <= cnt_q + CNT_ONE;
            case (state_q)
                FETCH:    if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    op_q    <= bus.opcode;
                    state_q <= decode_next(bus.opcode);
                    if (decode_next(bus.opcode) == TRAP) illegal_q <= 1'b1;
                end
                // lw/sw split uses the opcode latched in DECODE, not the live one.
                MEM_ADDR: state_q <= (op_q == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD:   if (bus.mem_ready) state_q <= MEM_WB;
                MEM_WR:   if (bus.mem_ready) state_q <= FETCH;
                EXEC_R:   state_q <= (bus.funct == FUNCT_JR) ? FETCH : WB_R;
                EXEC_I:   state_q <= WB_I;
                MEM_WB, WB_R, WB_I, BRANCH, JUMP: state_q <= FETCH;
                TRAP:     state_q <= TRAP;
                default:  state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.iord     = 1'b0;
        bus.reg_we   = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = SRCB_REG;
        bus.aluop    = ALUOP_ADD;
        bus.pcsrc    = PCSRC_ALU;
        case (state_q)
            FETCH: begin
                bus.mem_rd  = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                bus.ir_we   = bus.mem_ready;
                bus.pc_we   = bus.mem_ready;
            end
            DECODE: bus.alusrcb = SRCB_IMM_SL2;
            MEM_ADDR, EXEC_I: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
            end
            MEM_RD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
            end
            MEM_WB: begin
                bus.reg_we   = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEM_WR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            EXEC_R: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNCT;
                if (bus.funct == FUNCT_JR) begin
                    bus.pc_we = 1'b1;
                    bus.pcsrc = PCSRC_REG;
                end
            end
            WB_R: begin
                bus.reg_we = 1'b1;
                bus.regdst = 1'b1;
            end
            WB_I: bus.reg_we = 1'b1;
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_SUB;
                bus.pcsrc   = PCSRC_ALUOUT;
                bus.pc_we   = bus.zero;
            end
            JUMP: begin
                bus.pc_we = 1'b1;
                bus.pcsrc = PCSRC_JUMP;
            end
            default: ;
        endcase
        // Reset parks the FSM in FETCH; keep its read request quiet until release.
        if (rst) begin
            bus.ir_we  = 1'b0;
            bus.pc_we  = 1'b0;
            bus.mem_rd = 1'b0;
            bus.mem_wr = 1'b0;
            bus.reg_we = 1'b0;
        end
    end

    assign bus.illegal   = illegal_q;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a 32-bit and a 4-bit counter instance run
// the same randomized instruction stream against a per-instruction cycle model.
module tb_mc_control;
  import mc_pkg::*;

  logic clk;
  logic rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic mem_ready;
  logic zero;

  int checks;
  int errors;
  logic [31:0] exp_cnt;
  // entry: {mem_ready to drive, expected state[3:0], expected signals[9:0]}
  logic [14:0] exp_q[$];

  // signal bits: ir_we pc_we mem_rd mem_wr iord reg_we regdst memtoreg pcsrc[1:0]
  localparam logic [9:0] B_IR   = 10'h200;
  localparam logic [9:0] B_PC   = 10'h100;
  localparam logic [9:0] B_RD   = 10'h080;
  localparam logic [9:0] B_WR   = 10'h040;
  localparam logic [9:0] B_IORD = 10'h020;
  localparam logic [9:0] B_REG  = 10'h010;
  localparam logic [9:0] B_DST  = 10'h008;
  localparam logic [9:0] B_M2R  = 10'h004;

  mc_control_if #(.CNT_W(32)) if32 ();
  mc_control_if #(.CNT_W(4))  if4 ();

  assign if32.opcode = opcode;
  assign if32.funct = funct;
  assign if32.mem_ready = mem_ready;
  assign if32.zero = zero;
  assign if4.opcode = opcode;
  assign if4.funct = funct;
  assign if4.mem_ready = mem_ready;
  assign if4.zero = zero;

  mc_control #(.CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  mc_control #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

  logic [9:0] obs32, obs4;
  assign obs32 = {if32.ir_we, if32.pc_we, if32.mem_rd, if32.mem_wr, if32.iord,
                  if32.reg_we, if32.regdst, if32.memtoreg, if32.pcsrc};
  assign obs4 = {if4.ir_we, if4.pc_we, if4.mem_rd, if4.mem_wr, if4.iord,
                 if4.reg_we, if4.regdst, if4.memtoreg, if4.pcsrc};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ent(input logic rdy, input state_t st, input logic [9:0] s);
    return {rdy, 4'(st), s};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: the cycle-by-cycle plan of one instruction from the ISA rules.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    for (int i = 0; i < fw; i++) exp_q.push_back(ent(1'b0, FETCH, B_RD));
    exp_q.push_back(ent(1'b1, FETCH, B_IR | B_PC | B_RD));
    exp_q.push_back(ent(rnd_bit(), DECODE, 10'h000));
    case (op)
      OP_LW: begin
        exp_q.push_back(ent(rnd_bit(), MEM_ADDR, 10'h000));
        for (int i = 0; i < mw; i++) exp_q.push_back(ent(1'b0, MEM_RD, B_RD | B_IORD));
        exp_q.push_back(ent(1'b1, MEM_RD, B_RD | B_IORD));
        exp_q.push_back(ent(rnd_bit(), MEM_WB, B_REG | B_M2R));
      end
      OP_SW: begin
        exp_q.push_back(ent(rnd_bit(), MEM_ADDR, 10'h000));
        for (int i = 0; i < mw; i++) exp_q.push_back(ent(1'b0, MEM_WR, B_WR | B_IORD));
        exp_q.push_back(ent(1'b1, MEM_WR, B_WR | B_IORD));
      end
      OP_RTYPE: begin
        if (fn == FUNCT_JR) exp_q.push_back(ent(rnd_bit(), EXEC_R, B_PC | 10'h003));
        else begin
          exp_q.push_back(ent(rnd_bit(), EXEC_R, 10'h000));
          exp_q.push_back(ent(rnd_bit(), WB_R, B_REG | B_DST));
        end
      end
      OP_ADDI: begin
        exp_q.push_back(ent(rnd_bit(), EXEC_I, 10'h000));
        exp_q.push_back(ent(rnd_bit(), WB_I, B_REG));
      end
      OP_BEQ: exp_q.push_back(ent(rnd_bit(), BRANCH, (z ? B_PC : 10'h000) | 10'h001));
      OP_J:   exp_q.push_back(ent(rnd_bit(), JUMP, B_PC | 10'h002));
      default: for (int i = 0; i < 10; i++) exp_q.push_back(ent(rnd_bit(), TRAP, 10'h000));
    endcase
  endtask

  // Driver: plays the plan, scrambling opcode after DECODE, then checks the counters.
  task automatic drive_plan(input logic [5:0] op);
    logic [14:0] e;
    logic [3:0] est;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      est = e[13:10];
      @(negedge clk);
      mem_ready = e[14];
      if (est == 4'(FETCH) || est == 4'(DECODE)) opcode = op;
      else opcode = 6'($urandom);
      #1;
      checks++;
      if (if32.state !== est || obs32 !== e[9:0]) begin
        errors++;
        $display("FAIL cycle32: state=%0d sig=%b required state=%0d sig=%b", if32.state, obs32, est, e[9:0]);
      end
      checks++;
      if (if4.state !== est || obs4 !== e[9:0]) begin
        errors++;
        $display("FAIL cycle4: state=%0d sig=%b required state=%0d sig=%b", if4.state, obs4, est, e[9:0]);
      end
      checks++;
      if (if32.illegal !== (est == 4'(TRAP))) begin
        errors++;
        $display("FAIL illegal: got %b required %b (state %0d)", if32.illegal, est == 4'(TRAP), est);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (if32.instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt32: got %0d required %0d", if32.instr_cnt, exp_cnt);
    end
    checks++;
    if (if4.instr_cnt !== exp_cnt[3:0]) begin
      errors++;
      $display("FAIL cnt4: got %0d required %0d", if4.instr_cnt, exp_cnt[3:0]);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    funct = fn;
    zero = z;
    plan_instr(op, fn, z, fw, mw);
    exp_cnt = exp_cnt + 32'd1;
    drive_plan(op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (if32.state !== 4'(FETCH) || obs32 !== 10'h000 || if32.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d sig=%b illegal=%b required 0/0/0", if32.state, obs32, if32.illegal);
    end
    checks++;
    if (if32.instr_cnt !== 32'd0 || if4.instr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d required 0", if32.instr_cnt, if4.instr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_cnt = 32'd0;
    #1;
    checks++;
    if (if32.mem_rd !== 1'b1 || if32.iord !== 1'b0 || if32.state !== 4'(FETCH)) begin
      errors++;
      $display("FAIL first_fetch: mem_rd=%b iord=%b state=%0d required 1/0/0", if32.mem_rd, if32.iord, if32.state);
    end
  endtask

  task automatic test_rtype_add();
    run_instr(OP_RTYPE, 6'h20, 1'b0, 0, 0);
    checks++;
    if (if32.instr_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rtype_cnt: got %0d required 1", if32.instr_cnt);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 6'h00, 1'b0, 0, 3);
  endtask

  task automatic test_beq();
    logic [31:0] base;
    base = exp_cnt;
    run_instr(OP_BEQ, 6'h00, 1'b0, 0, 0);
    run_instr(OP_BEQ, 6'h00, 1'b1, 1, 0);
    checks++;
    if (if32.instr_cnt !== base + 32'd2) begin
      errors++;
      $display("FAIL beq_cnt: got %0d required %0d", if32.instr_cnt, base + 32'd2);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    int sel;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_RTYPE; ops[3] = OP_RTYPE;
    ops[4] = OP_ADDI; ops[5] = OP_BEQ; ops[6] = OP_J;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 6);
      run_instr(ops[sel], (sel == 3) ? FUNCT_JR : 6'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_trap();
    funct = 6'h00;
    plan_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    drive_plan(6'h3F);
    do_reset();
    #1;
    checks++;
    if (if32.illegal !== 1'b0 || if32.state !== 4'(FETCH) || if32.instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL trap_clear: illegal=%b state=%0d cnt=%0d required 0/0/0", if32.illegal, if32.state, if32.instr_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    run_instr(OP_J, 6'h00, 1'b0, 0, 0);
    @(negedge clk);
    opcode = OP_SW;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (if32.state !== 4'(MEM_WR) || if32.mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL midwr_setup: state=%0d mem_wr=%b required %0d/1", if32.state, if32.mem_wr, MEM_WR);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (if32.state !== 4'(FETCH) || if32.mem_wr !== 1'b0 || if32.mem_rd !== 1'b0 || if32.instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL midwr_reset: state=%0d mem_wr=%b mem_rd=%b cnt=%0d required 0/0/0/0",
               if32.state, if32.mem_wr, if32.mem_rd, if32.instr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++) run_instr(OP_J, 6'h00, 1'b0, $urandom_range(0, 1), 0);
    checks++;
    if (if4.instr_cnt !== 4'd0 || if32.instr_cnt !== 32'd16) begin
      errors++;
      $display("FAIL wrap: cnt4=%0d cnt32=%0d required 0/16", if4.instr_cnt, if32.instr_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 32'd0;
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    mem_ready = 1'b0;
    zero = 1'b0;
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_beq();
    test_random();
    test_trap();
    test_reset_mid_write();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001: CNT_W, 32, width of retired-instruction counter.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: opcode  input  6  instr[31:26] from instruction decoder, sampled only in DECODE.
REQ-005: funct  input  6  instr[5:0]; R-type jr detect (6'h08).
REQ-006: mem_ready  input  1  memory completes current read/write this cycle.
REQ-007: zero  input  1  ALU equality flag for beq.
REQ-008: ir_we, pc_we, mem_rd, mem_wr, iord, reg_we, regdst, memtoreg, alusrca  output  1 each  datapath strobes/selects.
REQ-009: alusrcb  output  2  00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-010: aluop  output  2  00 add, 01 sub, 10 by funct.
REQ-011: pcsrc  output  2  00 ALU, 01 ALUOut (branch), 10 jump target, 11 register (jr).
REQ-012: illegal  output  1  sticky unsupported-opcode flag.
REQ-013: state  output  4  current FSM state encoding, for debug.
REQ-014: instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-015: FSM states SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, WB_R, WB_I, BRANCH, JUMP, TRAP.
REQ-016: FETCH: mem_rd=1, iord=0, alusrca=0, alusrcb=01, aluop=00; stays until mem_ready; on mem_ready cycle ir_we=1, pc_we=1, pcsrc=00, next DECODE.
REQ-017: DECODE: alusrcb=11, aluop=00 (branch target precompute); next by opcode: 6'h00 EXEC_R, 6'h23/6'h2B MEM_ADDR, 6'h08 EXEC_I, 6'h04 BRANCH, 6'h02 JUMP, any other TRAP.
REQ-018: MEM_ADDR: alusrca=1, alusrcb=10, aluop=00; next MEM_RD if lw, MEM_WR if sw (opcode latched in DECODE).
REQ-019: MEM_RD: mem_rd=1, iord=1; waits for mem_ready, then MEM_WB.
REQ-020: MEM_WB: reg_we=1, regdst=0, memtoreg=1; next FETCH; retires.
REQ-021: MEM_WR: mem_wr=1, iord=1; waits for mem_ready, then FETCH; retires on mem_ready cycle.
REQ-022: EXEC_R: alusrca=1, alusrcb=00, aluop=10; funct 6'h08 (jr): pc_we=1, pcsrc=11, next FETCH, retires; else next WB_R.
REQ-023: WB_R: reg_we=1, regdst=1, memtoreg=0; next FETCH; retires.
REQ-024: EXEC_I: alusrca=1, alusrcb=10, aluop=00; next WB_I. WB_I: reg_we=1, regdst=0, memtoreg=0; next FETCH; retires.
REQ-025: BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_we=zero; next FETCH; retires regardless of zero.
REQ-026: JUMP: pc_we=1, pcsrc=10; next FETCH; retires.
REQ-027: TRAP: illegal=1, all strobes 0; remains in TRAP until rst.
REQ-028: Outputs SHALL be combinational from state (and mem_ready/zero/funct where stated); unlisted outputs 0 in each state.
REQ-029: mem_rd/mem_wr SHALL stay asserted with stable iord every waiting cycle; no write strobe before mem_ready.
REQ-030: instr_cnt SHALL increment by 1 on each retiring cycle and wrap modulo 2^CNT_W; no saturation.
REQ-031: Opcode SHALL be captured into an internal register in DECODE; later opcode changes have no effect until next DECODE.

Reset
REQ-032: rst=1 SHALL asynchronously force state=FETCH, instr_cnt=0, illegal=0, latched opcode=0.
REQ-033: During reset all strobes (ir_we, pc_we, mem_rd, mem_wr, reg_we) SHALL be 0; mid-instruction reset aborts with no retirement.
REQ-034: First FETCH mem_rd SHALL assert in the first cycle after rst deasserts.

Structure
REQ-035: Package mc_pkg SHALL hold state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), FUNCT_JR, and alusrcb/aluop/pcsrc encodings.
REQ-036: Single module, no sub-modules; counter inline.

Verification
REQ-037: Reset, mem_ready=1 always, R-type add (opcode 0, funct 6'h20) -> FETCH,DECODE,EXEC_R,WB_R; reg_we=1,regdst=1 in WB_R; instr_cnt=1.
REQ-038: lw with mem_ready low 3 cycles in MEM_RD -> mem_rd,iord held 3 cycles, MEM_WB next, memtoreg=1; total 5 states + 3 waits.
REQ-039: beq with zero=0 then zero=1 -> pc_we 0 then 1, pcsrc=01; instr_cnt +2.
REQ-040: opcode 6'h3F -> TRAP, illegal=1 held 10 cycles, instr_cnt unchanged; rst clears.
REQ-041: rst asserted mid MEM_WR wait -> state=FETCH immediately, mem_wr=0, instr_cnt=0.
REQ-042: CNT_W=4, 16 jumps -> instr_cnt wraps to 0.
